// File: rtl/ac_table_pkg.sv
// Shared constants and state encoding for the Aho-Corasick table writer.
// The root-state constant is shared with the table reader.
package ac_table_pkg;

    localparam int unsigned DEPTH   = 32;
    localparam int unsigned ADDR_W  = $clog2(DEPTH);
    localparam int unsigned STATE_W = 8;
    localparam int unsigned CHARA_W = 4;

    // Byte position of each field inside a 4-byte record
    localparam int unsigned BYTE_CUR   = 0;
    localparam int unsigned BYTE_CHARA = 1;
    localparam int unsigned BYTE_NEXT  = 2;
    localparam int unsigned BYTE_FAIL  = 3;
    localparam int unsigned REC_BYTES  = 4;

    localparam logic [STATE_W-1:0] ROOT_STATE = '0;

    typedef enum logic [2:0] {
        StIdle,
        StBCur,
        StBChara,
        StBNext,
        StBFail,
        StCommit,
        StFin,
        StBCsum
    } wr_state_e;

endpackage

// File: rtl/ac_table_writer.sv
// Aho-Corasick table writer: packs a valid/ready byte stream into 4-byte
// records (cur, chara, next, fail) and writes each record into the table RAMs
// with a single strobe. Optional trailer checksum under AC_TABLE_WRITER_CHECKSUM_EN.
module ac_table_writer
    import ac_table_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               we,
    output logic [ADDR_W-1:0]  waddr,
    output logic [STATE_W-1:0] wdata_cur,
    output logic [CHARA_W-1:0] wdata_chara,
    output logic [STATE_W-1:0] wdata_next,
    output logic [STATE_W-1:0] wdata_fail,
    output logic [ADDR_W:0]    entry_count,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(DEPTH - 1);

    wr_state_e          state_q, state_d;
    logic [STATE_W-1:0] cur_q, next_q, fail_q;
    logic [CHARA_W-1:0] chara_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [ADDR_W:0]    count_q;
    logic               done_q, err_q, last_q;
    logic               xfer, set_err, set_done, rearm;
`ifdef AC_TABLE_WRITER_CHECKSUM_EN
    logic [7:0]         csum_q;
`endif

    assign xfer = in_valid & in_ready;

    // Output decode from state; the field registers drive the RAM data directly
    always_comb begin
        in_ready = (state_q inside {StBCur, StBChara, StBNext, StBFail, StBCsum});
        we       = (state_q == StCommit);
        busy     = (state_q != StIdle) && (state_q != StFin);
    end

    assign waddr       = waddr_q;
    assign wdata_cur   = cur_q;
    assign wdata_chara = chara_q;
    assign wdata_next  = next_q;
    assign wdata_fail  = fail_q;
    assign entry_count = count_q;
    assign done        = done_q;
    assign err         = err_q;

    // Next-state logic and sticky-flag requests
    always_comb begin
        state_d  = state_q;
        set_err  = 1'b0;
        set_done = 1'b0;
        rearm    = 1'b0;
        unique case (state_q)
            StIdle, StFin: begin
                if (start) begin
                    rearm   = 1'b1;
                    state_d = StBCur;
                end
            end
            StBCur: begin
                if (xfer) begin
                    // Table full or truncated record: abort without writing
                    if (count_q == FullCount || in_last) begin
                        set_err = 1'b1;
                        state_d = StFin;
                    end else begin
                        state_d = StBChara;
                    end
                end
            end
            StBChara: begin
                if (xfer) begin
                    if (in_data[7:CHARA_W] != '0 || in_last) begin
                        set_err = 1'b1;
                        state_d = StFin;
                    end else begin
                        state_d = StBNext;
                    end
                end
            end
            StBNext: begin
                if (xfer) begin
                    if (in_last) begin
                        set_err = 1'b1;
                        state_d = StFin;
                    end else begin
                        state_d = StBFail;
                    end
                end
            end
            StBFail: begin
                if (xfer) state_d = StCommit;
            end
            StCommit: begin
                if (last_q) begin
`ifdef AC_TABLE_WRITER_CHECKSUM_EN
                    state_d = StBCsum;
`else
                    set_done = 1'b1;
                    state_d  = StFin;
`endif
                end else begin
                    state_d = StBCur;
                end
            end
`ifdef AC_TABLE_WRITER_CHECKSUM_EN
            StBCsum: begin
                if (xfer) begin
                    state_d = StFin;
                    if (in_data == csum_q) set_done = 1'b1;
                    else                   set_err  = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Record field capture, address/count bookkeeping and sticky status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q   <= ROOT_STATE;
            chara_q <= '0;
            next_q  <= ROOT_STATE;
            fail_q  <= ROOT_STATE;
            waddr_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else if (rearm) begin
            waddr_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            if (set_err)  err_q  <= 1'b1;
            if (set_done) done_q <= 1'b1;
            if (xfer && state_q == StBCur)   cur_q   <= in_data[STATE_W-1:0];
            if (xfer && state_q == StBChara) chara_q <= in_data[CHARA_W-1:0];
            if (xfer && state_q == StBNext)  next_q  <= in_data[STATE_W-1:0];
            if (xfer && state_q == StBFail) begin
                fail_q <= in_data[STATE_W-1:0];
                last_q <= in_last;
            end
            if (state_q == StCommit) begin
                count_q <= count_q + 1'b1;
                // Address saturates at the last row; overflow is caught in StBCur
                if (waddr_q != LastAddr) waddr_q <= waddr_q + 1'b1;
            end
        end
    end

`ifdef AC_TABLE_WRITER_CHECKSUM_EN
    // Running XOR of every record byte accepted in this load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (rearm) begin
            csum_q <= '0;
        end else if (xfer && state_q != StBCsum) begin
            csum_q <= csum_q ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_ac_table_writer.sv
// Scoreboard bench for ac_table_writer (default build, no trailer checksum).
module tb_ac_table_writer;
    import ac_table_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [7:0]         in_data = '0;
    logic               in_last = 1'b0;
    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [STATE_W-1:0] wdata_cur;
    logic [CHARA_W-1:0] wdata_chara;
    logic [STATE_W-1:0] wdata_next;
    logic [STATE_W-1:0] wdata_fail;
    logic [ADDR_W:0]    entry_count;
    logic               busy, done, err;

    ac_table_writer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .we(we),
        .waddr(waddr), .wdata_cur(wdata_cur), .wdata_chara(wdata_chara),
        .wdata_next(wdata_next), .wdata_fail(wdata_fail),
        .entry_count(entry_count), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        int unsigned cur;
        int unsigned chara;
        int unsigned nxt;
        int unsigned fl;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  stim_b[$];
    bit          stim_l[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_cnt;
    bit          exp_done, exp_err;
    int          n_consume;
    bit          gaps = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (we) begin
                check("ready_low_in_commit", in_ready, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", waddr, 999);
                end else begin
                    e = exp_q.pop_front();
                    check("waddr", waddr, e.addr);
                    check("wdata_cur", wdata_cur, e.cur);
                    check("wdata_chara", wdata_chara, e.chara);
                    check("wdata_next", wdata_next, e.nxt);
                    check("wdata_fail", wdata_fail, e.fl);
                end
            end
        end
    end

    task automatic add_rec(input int c, input int ch, input int n, input int f, input bit last);
        stim_b.push_back(8'(c)); stim_l.push_back(1'b0);
        stim_b.push_back(8'(ch)); stim_l.push_back(1'b0);
        stim_b.push_back(8'(n)); stim_l.push_back(1'b0);
        stim_b.push_back(8'(f)); stim_l.push_back(last);
    endtask

    // Reference: walk the stream as records, stop at the first rule violation
    task automatic model();
        int i;
        exp_cnt = 0; exp_done = 0; exp_err = 0; n_consume = stim_b.size();
        for (i = 0; i < stim_b.size(); i++) begin
            int pos = i % REC_BYTES;
            if (pos == BYTE_CUR && exp_cnt == DEPTH) begin exp_err = 1; break; end
            if (pos == BYTE_CHARA && stim_b[i] >= 8'(1 << CHARA_W)) begin exp_err = 1; break; end
            if (stim_l[i] && pos != BYTE_FAIL) begin exp_err = 1; break; end
            if (pos == BYTE_FAIL) begin
                wr_t w;
                w.addr = exp_cnt; w.cur = stim_b[i-3]; w.chara = stim_b[i-2];
                w.nxt = stim_b[i-1]; w.fl = stim_b[i];
                exp_q.push_back(w);
                exp_cnt++;
                if (stim_l[i]) begin exp_done = 1; break; end
            end
        end
        if (i < stim_b.size()) n_consume = i + 1;
    endtask

    // Drive one byte; may also pulse START while busy, which must be ignored
    task automatic send_byte(input logic [7:0] b, input bit l);
        int waited = 0;
        while (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_data = b; in_last = l;
        start = ($urandom_range(0, 7) == 0);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk); #1;
            waited++;
            if (waited > 40) begin
                check("byte_accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_load(input string name);
        int waited = 0;
        model();
        pulse_start();
        for (int i = 0; i < n_consume; i++) send_byte(stim_b[i], stim_l[i]);
        while (busy && waited < 60) begin @(posedge clk); #1; waited++; end
        repeat (2) @(posedge clk);
        #1;
        check({name, "_busy_cleared"}, busy, 0);
        check({name, "_done"}, done, exp_done);
        check({name, "_err"}, err, exp_err);
        check({name, "_entry_count"}, entry_count, exp_cnt);
        check({name, "_writes_outstanding"}, exp_q.size(), 0);
        exp_q.delete();
        stim_b.delete(); stim_l.delete();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_outs"},
              {in_ready, we, waddr, wdata_cur, wdata_chara, wdata_next, wdata_fail,
               entry_count, busy, done, err}, 0);
    endtask

    initial begin
        #2;
        check_all_zero("reset");
        #20;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", in_ready, 0);

        // Single fixed record
        add_rec(8'h00, 8'h0B, 8'h01, 8'h00, 1);
        run_load("single");

        // Three random records with random valid gaps
        gaps = 1'b1;
        for (int r = 0; r < 3; r++)
            add_rec($urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 255),
                    $urandom_range(0, 255), r == 2);
        run_load("three");

        // Bad character byte
        add_rec(8'h00, 8'h1B, 8'h01, 8'h00, 1);
        run_load("bad_chara");

        // Truncated second record
        add_rec(8'h01, 8'h02, 8'h03, 8'h04, 0);
        add_rec(8'h05, 8'h06, 8'h07, 8'h08, 1);
        stim_l[5] = 1'b1;
        run_load("truncated");

        // 33 records against a 32-row table
        gaps = 1'b0;
        for (int r = 0; r < 33; r++)
            add_rec($urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 255),
                    $urandom_range(0, 255), r == 32);
        run_load("overflow");

        // Reset mid-record, then a fresh two-record load
        pulse_start();
        send_byte(8'h11, 0);
        send_byte(8'h02, 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst_async");
        @(posedge clk); #1;
        check_all_zero("midrst_held");
        rst_n = 1'b1;
        @(posedge clk); #1;
        gaps = 1'b1;
        add_rec(8'h21, 8'h03, 8'h22, 8'h00, 0);
        add_rec(8'h22, 8'h04, 8'h23, 8'h21, 1);
        run_load("after_rst");

        // Random loads with occasional bad characters or early IN_LAST
        for (int t = 0; t < 6; t++) begin
            int nrec = $urandom_range(1, 6);
            for (int r = 0; r < nrec; r++)
                add_rec($urandom_range(0, 255),
                        ($urandom_range(0, 9) == 0) ? $urandom_range(16, 255) : $urandom_range(0, 15),
                        $urandom_range(0, 255), $urandom_range(0, 255), r == nrec - 1);
            if ($urandom_range(0, 3) == 0) stim_l[$urandom_range(0, stim_l.size() - 1)] = 1'b1;
            run_load("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ac_table_writer.md
Name: ac_table_writer

Overview:
- Loads the Aho-Corasick goto/failure tables that the table reader consumes.
- Accepts a byte stream over a valid/ready handshake and packs each 4-byte record as current-state, character, next-state, failure-state.
- Issues one write strobe per record into the four table RAMs, which share the same address.
- Sits between the host/config loader and the table RAMs; runs once per table load, before matching starts.

Parameters:
- DEPTH, 32, number of table entries (RAM rows).
- ADDR_W, 5, table address width; equals clog2(DEPTH).
- STATE_W, 8, state field width.
- CHARA_W, 4, character code width.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset; asynchronous, active-low.
- START  in  1  one-cycle pulse; begins a new load at address 0.
- IN_VALID  in  1  IN_DATA byte valid.
- IN_READY  out  1  writer accepts the byte this cycle.
- IN_DATA  in  8  record byte.
- IN_LAST  in  1  marks the final byte of the final record.
- WE  out  1  table write strobe, one cycle per record.
- WADDR  out  ADDR_W  write address.
- WDATA_CUR  out  STATE_W  current-state field.
- WDATA_CHARA  out  CHARA_W  character field.
- WDATA_NEXT  out  STATE_W  next-state field.
- WDATA_FAIL  out  STATE_W  failure-state field.
- ENTRY_COUNT  out  ADDR_W+1  records committed in this load.
- BUSY  out  1  load in progress.
- DONE  out  1  load finished cleanly; sticky until next START.
- ERR  out  1  format or overflow error; sticky until next START.

Behaviour:
- Reset (RST=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including IN_READY, WE, WADDR, the WDATA_* fields, ENTRY_COUNT, BUSY, DONE and ERR.
- States: IDLE, B_CUR, B_CHARA, B_NEXT, B_FAIL, COMMIT, FIN.
- IDLE:
  - IN_READY=0; input bytes are not consumed.
  - START moves to B_CUR; ENTRY_COUNT, WADDR, DONE and ERR clear to 0; BUSY goes to 1.
- Byte states:
  - IN_READY=1. A byte transfers only when IN_VALID & IN_READY in the same cycle.
  - B_CUR -> B_CHARA -> B_NEXT -> B_FAIL, one transfer each; each byte is latched into its field register.
  - B_CHARA: IN_DATA[7:CHARA_W] must be 0. Otherwise ERR=1 and go to FIN.
- IN_LAST:
  - IN_LAST with a transfer in B_CUR, B_CHARA or B_NEXT is a truncated record: ERR=1, go to FIN, no write.
  - IN_LAST in B_FAIL marks the final record.
- COMMIT, entered from B_FAIL after the transfer:
  - WE=1 for exactly one cycle with WADDR and all WDATA_* stable; IN_READY=0.
  - Next cycle: WADDR and ENTRY_COUNT increment.
  - If the final record was flagged, go to FIN and set DONE=1. Otherwise go to B_CUR.
- Latency: WE asserts the cycle after the 4th byte transfers. Peak throughput is one record per 5 cycles.
- Overflow: a transfer in B_CUR while ENTRY_COUNT==DEPTH sets ERR=1 and goes to FIN with no write. WADDR never wraps.
- FIN: BUSY=0 and IN_READY=0. START re-arms the writer (same as from IDLE).
- START while BUSY is ignored.
- WE is never asserted outside COMMIT.
- RST mid-load aborts immediately. Partial RAM contents are not rolled back; ENTRY_COUNT reads 0.
- DONE and ERR are never both 1.

Optional Feature:
- Macro: AC_TABLE_WRITER_CHECKSUM_EN.
- Defined:
  - A trailer byte follows the byte that carries IN_LAST; that trailer byte has IN_LAST=0.
  - The trailer must equal the XOR of all preceding record bytes of the load.
  - Add state B_CSUM after the final COMMIT.
  - On mismatch, ERR=1 and DONE=0; records are already written.
  - On match, DONE=1.
- Undefined: no trailer; FIN follows the final COMMIT directly.

Decomposition:
- Package ac_table_pkg holds:
  - DEPTH, ADDR_W, STATE_W, CHARA_W;
  - the state enum for this block;
  - the byte-index constants for the record layout;
  - the root-state constant 0, shared with the reader.
- No sub-module required. An optional ac_byte_xor accumulator is used only under AC_TABLE_WRITER_CHECKSUM_EN.

Test Plan:
- Single record: START, then bytes 00,0B,01,00 with IN_LAST on the 4th -> one WE at WADDR=0 with CUR=00, CHARA=B, NEXT=01, FAIL=00; DONE=1; ENTRY_COUNT=1.
- Three records with IN_VALID toggled randomly -> WE at WADDR 0,1,2, each exactly once; values match; IN_READY=0 during every COMMIT.
- Character byte 0x1B -> ERR=1, no WE, ENTRY_COUNT=0, DONE=0.
- IN_LAST on byte 2 of record 2 -> ERR=1; only WADDR=0 written; ENTRY_COUNT=1.
- 33 records -> 32 writes (WADDR 0..31); first byte of record 33 sets ERR=1; no write at address 0 again.
- RST low for 1 cycle mid-record, then START and a fresh 2-record stream -> all outputs 0 during reset; clean writes at WADDR 0,1; DONE=1.
